// File: rtl/cv32e40x_pkg.sv
// +----------------------------------------------------------------------------+
// | cv32e40x_pkg: shared types for the XIF result scheduler                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cv32e40x_pkg;

  // Slot ID storage is sized for the widest supported XIF ID; narrower IDs are zero-extended.
  localparam int unsigned X_ID_MAX_W = 8;

  typedef enum logic [1:0] {
    XIF_SLOT_FREE = 2'd0,
    XIF_SLOT_WAIT = 2'd1,
    XIF_SLOT_DONE = 2'd2
  } xif_slot_state_e;

  typedef struct packed {
    logic [X_ID_MAX_W-1:0] id;
    logic [31:0]           data;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    xif_slot_state_e       state;
  } xif_slot_t;

  localparam xif_slot_t XIF_SLOT_RESET = '{
    id:    '0,
    data:  '0,
    rd:    '0,
    we:    1'b0,
    exc:   1'b0,
    state: XIF_SLOT_FREE
  };

endpackage

`default_nettype wire

// File: rtl/cv32e40x_xif_result_sched_sva.sv
// +----------------------------------------------------------------------------+
// | cv32e40x_xif_result_sched_sva: protocol checks bound into the scheduler    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cv32e40x_xif_result_sched_sva
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic      clk,
  input logic      rst_n,
  input logic      issue_valid_i,
  input logic      issue_ready_o,
  input logic      wb_xif_valid_i,
  input logic      wb_done_i,
  input xif_slot_t slot_q [DEPTH]
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic dup_wait;

  always_comb begin
    dup_wait = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = i + 1; j < DEPTH; j++) begin
        if ((slot_q[PTR_W'(i)].state == XIF_SLOT_WAIT) &&
            (slot_q[PTR_W'(j)].state == XIF_SLOT_WAIT) &&
            (slot_q[PTR_W'(i)].id == slot_q[PTR_W'(j)].id)) begin
          dup_wait = 1'b1;
        end
      end
    end
  end

  a_issue_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    (issue_valid_i && !issue_ready_o) |-> (wb_xif_valid_i && wb_done_i));

  a_unique_wait_id: assert property (@(posedge clk) disable iff (!rst_n) !dup_wait);

endmodule

bind cv32e40x_xif_result_sched cv32e40x_xif_result_sched_sva #(.DEPTH(DEPTH)) u_sva (
  .clk            (clk),
  .rst_n          (rst_n),
  .issue_valid_i  (issue_valid_i),
  .issue_ready_o  (issue_ready_o),
  .wb_xif_valid_i (wb_xif_valid_i),
  .wb_done_i      (wb_done_i),
  .slot_q         (slot_q)
);

`default_nettype wire

// File: rtl/cv32e40x_xif_result_sched.sv
// +----------------------------------------------------------------------------+
// | cv32e40x_xif_result_sched: in-order tracker for out-of-order XIF results   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cv32e40x_xif_result_sched
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            issue_valid_i,
  input  logic [ID_W-1:0] issue_id_i,
  output logic            issue_ready_o,

  input  logic            kill_i,

  input  logic            x_result_valid_i,
  output logic            x_result_ready_o,
  input  logic [ID_W-1:0] x_result_id_i,
  input  logic [31:0]     x_result_data_i,
  input  logic [4:0]      x_result_rd_i,
  input  logic            x_result_we_i,
  input  logic            x_result_exc_i,

  input  logic            wb_xif_valid_i,
  input  logic [ID_W-1:0] wb_id_i,
  input  logic            wb_done_i,

  output logic            wb_result_valid_o,
  output logic [31:0]     wb_result_data_o,
  output logic [4:0]      wb_result_rd_o,
  output logic            wb_result_we_o,
  output logic            wb_result_exc_o,

  output logic            err_unexpected_o,
  output logic            err_order_o
);

  localparam int unsigned     PTR_W    = $clog2(DEPTH);
  localparam int unsigned     CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  xif_slot_t              slot_q [DEPTH];
  xif_slot_t              slot_d [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   err_unexp_q, err_unexp_d;

  logic [DEPTH-1:0]       match;
  logic                   full;
  logic                   pop;
  logic                   issue;
  logic [X_ID_MAX_W-1:0]  res_id_ext;
  logic [X_ID_MAX_W-1:0]  wb_id_ext;
  xif_slot_t              head_slot;

  assign res_id_ext = X_ID_MAX_W'(x_result_id_i);
  assign wb_id_ext  = X_ID_MAX_W'(wb_id_i);
  assign head_slot  = slot_q[head_q];

  assign full  = (count_q == CNT_FULL);
  assign pop   = wb_done_i && wb_xif_valid_i && (count_q != '0);
  // A pop frees the head slot this cycle, so a full tracker may still take one issue.
  assign issue = issue_valid_i && (!full || pop);

  // Only WAIT slots can match; slots written this cycle are still FREE and cannot.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match[i] = (slot_q[i].state == XIF_SLOT_WAIT) && (slot_q[i].id == res_id_ext);
  end

  always_comb begin
    slot_d      = slot_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    err_unexp_d = x_result_valid_i && !(|match);

    if (kill_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_d[PTR_W'(i)].state = XIF_SLOT_FREE;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (x_result_valid_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (match[PTR_W'(i)]) begin
            slot_d[PTR_W'(i)].data  = x_result_data_i;
            slot_d[PTR_W'(i)].rd    = x_result_rd_i;
            slot_d[PTR_W'(i)].we    = x_result_we_i;
            slot_d[PTR_W'(i)].exc   = x_result_exc_i;
            slot_d[PTR_W'(i)].state = XIF_SLOT_DONE;
          end
        end
      end

      // Pop after capture so a same-cycle result for the head is discarded.
      if (pop) begin
        slot_d[head_q].state = XIF_SLOT_FREE;
        head_d               = head_q + 1'b1;
      end

      if (issue) begin
        slot_d[tail_q].id    = X_ID_MAX_W'(issue_id_i);
        slot_d[tail_q].state = XIF_SLOT_WAIT;
        tail_d               = tail_q + 1'b1;
      end

      count_d = count_q + CNT_W'(issue) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '{default: XIF_SLOT_RESET};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      err_unexp_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  assign issue_ready_o    = !full;
  assign x_result_ready_o = 1'b1;

  assign wb_result_valid_o = wb_xif_valid_i &&
                             (head_slot.state == XIF_SLOT_DONE) &&
                             (head_slot.id == wb_id_ext);
  assign wb_result_data_o  = wb_result_valid_o ? head_slot.data : 32'd0;
  assign wb_result_rd_o    = wb_result_valid_o ? head_slot.rd   : 5'd0;
  assign wb_result_we_o    = wb_result_valid_o && head_slot.we;
  assign wb_result_exc_o   = wb_result_valid_o && head_slot.exc;

  assign err_unexpected_o = err_unexp_q;
  assign err_order_o      = wb_xif_valid_i && (count_q != '0) && (head_slot.id != wb_id_ext);

endmodule

`default_nettype wire
